// File: rtl/data_bus_bridge.sv
// data_bus_bridge: connects a single-cycle core's load/store port to a valid/ready bus.
// It holds the core with stall while a request is outstanding, and shapes store lanes and
// byte enables. It also extracts and extends load data and aborts reads that get no
// response within TIMEOUT cycles.
//
// Ports:
//   clk, reset                : clock; asynchronous active-low reset
//   addr, wdata               : core byte address and store data
//   mem_write, mem_read       : core store / load request
//   funct3                    : access size and signedness (B, H, W, BU, HU)
//   rdata, stall              : extended load data; core hold
//   misalign, bus_err         : misaligned access; read aborted on timeout
//   req_valid, req_ready, req_addr, req_we, req_wdata, req_be : bus request channel
//   rsp_valid, rsp_rdata      : bus read-response channel
module data_bus_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic        req_we,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StDone} state_e;

    localparam logic [1:0]  SzB      = 2'd0;
    localparam logic [1:0]  SzH      = 2'd1;
    localparam logic [1:0]  SzW      = 2'd2;
    localparam logic [31:0] TimeoutW = TIMEOUT;

    state_e      r_state, w_next;
    logic [31:0] r_req_addr, r_req_wdata, r_rdata, r_cnt;
    logic [3:0]  r_req_be;
    logic        r_req_we, r_bus_err, r_sext;
    logic [1:0]  r_size, r_lo;

    logic [1:0]  w_size;
    logic        w_access, w_aligned, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_store, w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Request decode; unsupported funct3 codes fall back to a word access.
    always_comb begin
        w_size = SzW;
        unique case (funct3)
            3'b000, 3'b100: w_size = SzB;
            3'b001, 3'b101: w_size = SzH;
            default:        w_size = SzW;
        endcase
        w_access  = mem_read | mem_write;
        w_aligned = 1'b1;
        w_be      = 4'hF;
        w_store   = wdata;
        if (w_size == SzH) begin
            w_aligned = ~addr[0];
            w_store   = {2{wdata[15:0]}};
            if (mem_write) w_be = 4'b0011 << addr[1:0];
        end else if (w_size == SzB) begin
            w_store   = {4{wdata[7:0]}};
            if (mem_write) w_be = 4'b0001 << addr[1:0];
        end else begin
            w_aligned = (addr[1:0] == 2'b00);
        end
    end

    // Load extraction uses the lane offset latched with the request.
    always_comb begin
        w_byte = 8'h00;
        unique case (r_lo)
            2'd0: w_byte = rsp_rdata[7:0];
            2'd1: w_byte = rsp_rdata[15:8];
            2'd2: w_byte = rsp_rdata[23:16];
            2'd3: w_byte = rsp_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
        if (r_size == SzB) begin
            w_load = {{24{r_sext & w_byte[7]}}, w_byte};
        end else if (r_size == SzH) begin
            w_load = {{16{r_sext & w_half[15]}}, w_half};
        end else begin
            w_load = rsp_rdata;
        end
    end

    // Abort when the count including this cycle reaches TIMEOUT, so TIMEOUT=0 and 1 both
    // give a single waiting cycle and TIMEOUT=N gives N.
    assign w_timeout = (r_cnt + 32'd1) >= TimeoutW;

    always_comb begin
        w_next   = r_state;
        stall    = 1'b0;
        misalign = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_access) begin
                    if (w_aligned) begin
                        w_next = StReq;
                        stall  = 1'b1;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            StReq: begin
                stall = 1'b1;
                if (req_ready) w_next = r_req_we ? StDone : StWaitRsp;
            end
            StWaitRsp: begin
                stall = 1'b1;
                if (rsp_valid || w_timeout) w_next = StDone;
            end
            StDone: w_next = StIdle;
            default: w_next = StIdle;
        endcase
        // Core-facing combinational outputs stay quiet while reset is held.
        stall    = stall & reset;
        misalign = misalign & reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_req_addr  <= 32'h0;
            r_req_wdata <= 32'h0;
            r_req_be    <= 4'h0;
            r_req_we    <= 1'b0;
            r_rdata     <= 32'h0;
            r_bus_err   <= 1'b0;
            r_cnt       <= 32'h0;
            r_size      <= SzW;
            r_sext      <= 1'b0;
            r_lo        <= 2'd0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                StIdle: begin
                    if (w_access && w_aligned) begin
                        r_req_addr  <= {addr[31:2], 2'b00};
                        r_req_we    <= mem_write;
                        r_req_be    <= w_be;
                        r_req_wdata <= w_store;
                        r_size      <= w_size;
                        r_sext      <= ~funct3[2];
                        r_lo        <= addr[1:0];
                    end
                end
                StReq: begin
                    if (req_ready) r_cnt <= 32'h0;
                end
                StWaitRsp: begin
                    if (rsp_valid) begin
                        r_rdata <= w_load;
                    end else if (w_timeout) begin
                        r_rdata   <= 32'h0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                StDone: r_bus_err <= 1'b0;
                default: ;
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign bus_err   = r_bus_err;
    assign req_valid = (r_state == StReq);
    assign req_addr  = r_req_addr;
    assign req_we    = r_req_we;
    assign req_be    = r_req_be;
    assign req_wdata = r_req_wdata;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Self-checking bench for data_bus_bridge (TIMEOUT=4): a directed vector table, reset and
// stray-response sequences, then random accesses checked against a behavioural model.
module tb_data_bus_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata, req_addr, req_wdata, rsp_rdata;
    logic        mem_write, mem_read, stall, misalign, bus_err;
    logic        req_valid, req_ready, req_we, rsp_valid;
    logic [2:0]  funct3;
    logic [3:0]  req_be;

    data_bus_bridge #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .funct3    (funct3),
        .rdata     (rdata),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Results observed by run_txn.
    int          o_stall, o_rv;
    logic        o_mis, o_done, o_unstable, o_err_out, o_err;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_be;
    logic        o_we;

    // Drive one core access; called at posedge+1 of an IDLE cycle.
    task automatic run_txn(input logic we, input logic re, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int rd,
                           input int rdly, input logic [31:0] word);
        int  cyc = 0;
        logic mis_mode = 1'b0;
        logic first = 1'b1;
        mem_write = we; mem_read = re; funct3 = f3; addr = a; wdata = wd;
        o_stall = 0; o_rv = 0; o_mis = 0; o_done = 0; o_unstable = 0; o_err_out = 0;
        o_err = 0; o_addr = 0; o_wdata = 0; o_rdata = 0; o_be = 0; o_we = 0;
        while (!o_done && cyc < 40) begin
            req_ready = (cyc >= 1 + rd);
            rsp_valid = (cyc == 2 + rd + rdly);
            rsp_rdata = rsp_valid ? word : $urandom;
            @(negedge clk);
            if (stall) o_stall++;
            if (misalign) o_mis = 1'b1;
            if (req_valid) begin
                o_rv++;
                if (first) begin
                    o_addr = req_addr; o_wdata = req_wdata; o_be = req_be; o_we = req_we;
                    first = 1'b0;
                end else if (o_addr !== req_addr || o_wdata !== req_wdata ||
                             o_be !== req_be || o_we !== req_we) begin
                    o_unstable = 1'b1;
                end
            end
            if (cyc == 0 && misalign) mis_mode = 1'b1;
            if (mis_mode) begin
                if (bus_err) o_err_out = 1'b1;
                if (cyc == 3) o_done = 1'b1;
            end else if (cyc > 0 && !stall) begin
                o_done = 1'b1; o_rdata = rdata; o_err = bus_err;
            end else if (bus_err) begin
                o_err_out = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_write = 0; mem_read = 0; req_ready = 0; rsp_valid = 0;
        chk("done_within_budget", {31'h0, o_done}, 32'h1);
    endtask

    task automatic check_txn(input logic exp_mis, input int exp_stall, input int rd,
                             input logic [31:0] e_addr, input logic [3:0] e_be,
                             input logic e_we, input logic [31:0] e_wdata,
                             input logic e_err, input logic [31:0] e_rdata);
        chk("misalign", {31'h0, o_mis}, {31'h0, exp_mis});
        chk("stall_cycles", o_stall, exp_stall);
        chk("bus_err_outside_done", {31'h0, o_err_out}, 32'h0);
        if (exp_mis) begin
            chk("req_valid_cycles", o_rv, 0);
        end else begin
            chk("req_valid_cycles", o_rv, rd + 1);
            chk("req_addr", o_addr, e_addr);
            chk("req_be", {28'h0, o_be}, {28'h0, e_be});
            chk("req_we", {31'h0, o_we}, {31'h0, e_we});
            if (e_we) chk("req_wdata", o_wdata, e_wdata);
            chk("req_stable", {31'h0, o_unstable}, 32'h0);
            chk("bus_err_done", {31'h0, o_err}, {31'h0, e_err});
            chk("rdata_done", o_rdata, e_rdata);
        end
    endtask

    typedef struct {
        logic        we, re;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        int          rd, rdly;
        logic [31:0] word;
        logic        mis;
        int          stall_n;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[13];

    // Behavioural reference for random accesses.
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] w);
        logic [31:0] v;
        int sh = 8 * int'(lo);
        case (size_of(f3))
            1: begin
                v = (w >> sh) & 32'hFF;
                if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
            end
            2: begin
                v = (w >> sh) & 32'hFFFF;
                if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    logic [31:0] model_rdata;

    initial begin
        reset = 0; addr = 0; wdata = 0; mem_write = 0; mem_read = 0; funct3 = 0;
        req_ready = 0; rsp_valid = 0; rsp_rdata = 0;
        #3;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_req_be", {28'h0, req_be}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1;

        //        we re f3      addr          wdata         rd rdly word        mis st addr      be      wdata         err rdata
        tbl[0]  = '{0, 1, 3'b010, 32'h104, 32'h0,        0, 1, 32'hDEADBEEF, 0, 4, 32'h104, 4'hF, 32'h0,        0, 32'hDEADBEEF};
        tbl[1]  = '{0, 1, 3'b000, 32'h103, 32'h0,        0, 0, 32'h80112233, 0, 3, 32'h100, 4'hF, 32'h0,        0, 32'hFFFFFF80};
        tbl[2]  = '{0, 1, 3'b100, 32'h103, 32'h0,        0, 0, 32'h80112233, 0, 3, 32'h100, 4'hF, 32'h0,        0, 32'h00000080};
        tbl[3]  = '{1, 0, 3'b001, 32'h202, 32'h0000ABCD, 3, 0, 32'h0,        0, 5, 32'h200, 4'hC, 32'hABCDABCD, 0, 32'h00000080};
        tbl[4]  = '{0, 1, 3'b010, 32'h101, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0};
        tbl[5]  = '{0, 1, 3'b010, 32'h108, 32'h0,        0, 9, 32'h12345678, 0, 6, 32'h108, 4'hF, 32'h0,        1, 32'h0};
        tbl[6]  = '{1, 0, 3'b000, 32'h001, 32'h12345678, 1, 0, 32'h0,        0, 3, 32'h000, 4'h2, 32'h78787878, 0, 32'h0};
        tbl[7]  = '{1, 1, 3'b010, 32'h300, 32'hCAFEF00D, 2, 0, 32'h0,        0, 4, 32'h300, 4'hF, 32'hCAFEF00D, 0, 32'h0};
        tbl[8]  = '{0, 1, 3'b111, 32'h308, 32'h0,        0, 2, 32'h11223344, 0, 5, 32'h308, 4'hF, 32'h0,        0, 32'h11223344};
        tbl[9]  = '{0, 1, 3'b111, 32'h302, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0};
        tbl[10] = '{0, 1, 3'b001, 32'h106, 32'h0,        1, 0, 32'h80017FFF, 0, 4, 32'h104, 4'hF, 32'h0,        0, 32'hFFFF8001};
        tbl[11] = '{0, 1, 3'b101, 32'h106, 32'h0,        0, 3, 32'h80017FFF, 0, 6, 32'h104, 4'hF, 32'h0,        0, 32'h00008001};
        tbl[12] = '{1, 0, 3'b001, 32'h201, 32'h1,        0, 0, 32'h0,        1, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0};

        foreach (tbl[i]) begin
            run_txn(tbl[i].we, tbl[i].re, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rd,
                    tbl[i].rdly, tbl[i].word);
            check_txn(tbl[i].mis, tbl[i].stall_n, tbl[i].rd, tbl[i].e_addr, tbl[i].e_be,
                      tbl[i].we, tbl[i].e_wdata, tbl[i].e_err, tbl[i].e_rdata);
        end

        // Stray responses while idle must not touch rdata.
        rsp_valid = 1; rsp_rdata = 32'h5A5A5A5A;
        repeat (3) begin
            @(negedge clk);
            chk("idle_rsp_rdata", rdata, 32'h00008001);
            chk("idle_rsp_stall", {31'h0, stall}, 32'h0);
            @(posedge clk); #1;
        end
        rsp_valid = 0;

        // Reset in WAIT_RSP, then a late response.
        mem_read = 1; funct3 = 3'b010; addr = 32'h104; req_ready = 1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("wait_stall", {31'h0, stall}, 32'h1);
        #1 reset = 0;
        #1;
        chk("midrst_req_valid", {31'h0, req_valid}, 32'h0);
        chk("midrst_stall", {31'h0, stall}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_req_addr", req_addr, 32'h0);
        chk("midrst_req_wdata", req_wdata, 32'h0);
        chk("midrst_req_be", {28'h0, req_be}, 32'h0);
        mem_read = 0; req_ready = 0;
        @(posedge clk); #1 reset = 1;
        rsp_valid = 1; rsp_rdata = 32'hDEADBEEF;
        repeat (3) begin
            @(negedge clk);
            chk("late_rsp_rdata", rdata, 32'h0);
            chk("late_rsp_req_valid", {31'h0, req_valid}, 32'h0);
            chk("late_rsp_stall", {31'h0, stall}, 32'h0);
            @(posedge clk); #1;
        end
        rsp_valid = 0;

        // Random accesses against the model.
        model_rdata = 32'h0;
        for (int n = 0; n < 120; n++) begin
            logic [1:0]  sel;
            logic        we, re, mis, err;
            logic [2:0]  f3;
            logic [31:0] a, wd, word, e_wdata;
            logic [3:0]  e_be;
            int          sz, rd, rdly, wait_n, st;
            logic [2:0]  f3s[8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                                    3'b011, 3'b110, 3'b111};
            sel  = 2'($urandom_range(1, 3));
            we   = sel[0]; re = sel[1];
            f3   = f3s[$urandom_range(0, 7)];
            sz   = size_of(f3);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
            wd   = $urandom; word = $urandom;
            rd   = $urandom_range(0, 3);
            rdly = $urandom_range(0, 6);
            mis  = (int'(a[1:0]) % sz) != 0;
            e_be = 4'hF;
            e_wdata = wd;
            if (we) begin
                e_be = 4'(((1 << sz) - 1) << a[1:0]);
                if (sz == 1) e_wdata = {24'h0, wd[7:0]} * 32'h01010101;
                if (sz == 2) e_wdata = {16'h0, wd[15:0]} * 32'h00010001;
            end
            err = 0;
            wait_n = 0;
            if (!we) begin
                if (rdly <= TO - 1) begin
                    wait_n = rdly + 1;
                    if (!mis) model_rdata = ext_model(f3, a[1:0], word);
                end else begin
                    wait_n = TO;
                    err = 1;
                    if (!mis) model_rdata = 32'h0;
                end
            end
            st = mis ? 0 : 1 + (rd + 1) + wait_n;
            run_txn(we, re, f3, a, wd, rd, rdly, word);
            check_txn(mis, st, rd, {a[31:2], 2'b00}, e_be, we, e_wdata, err, model_rdata);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
